// File: rtl/mips_pkg.sv
// Shared MIPS constants, fetch FSM state type and PC helpers for the fetch unit.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Sequential successor; wraps naturally at 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the instruction being handed to the decoder.
// Purely combinational; jump has priority over a taken branch.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] instr_pc_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    input  logic [31:0] branch_imm_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign seq_pc = pc_inc(instr_pc_i);
    assign br_tgt = seq_pc + {branch_imm_i[29:0], 2'b00};
    assign j_tgt  = {seq_pc[31:28], jump_index_i, 2'b00};

    always_comb begin
        next_pc_o = seq_pc;
        if (jump_i) begin
            next_pc_o = j_tgt;
        end else if (branch_i && zero_i) begin
            next_pc_o = br_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: IDLE -> REQ (wait ack) -> HOLD (wait decoder ready).
// Optional handshake counter instr_count is built only when FETCH_INSTR_CNT_EN is defined.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
`ifdef FETCH_INSTR_CNT_EN
    output logic [31:0] instr_count,
`endif
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] branch_imm,
    input  logic [25:0] jump_index
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  next_pc;
    logic         handshake;

    pc_next u_pc_next (
        .instr_pc_i   (instr_pc_q),
        .branch_i     (branch),
        .zero_i       (zero),
        .jump_i       (jump),
        .branch_imm_i (branch_imm),
        .jump_index_i (jump_index),
        .next_pc_o    (next_pc)
    );

    assign handshake = (state_q == HOLD) && instr_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                // Branch/jump inputs only matter here, on the accepting cycle.
                if (handshake) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;

`ifdef FETCH_INSTR_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (handshake) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table of fetch/handoff records plus a reset-during-request sequence.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch, zero, jump;
    logic [31:0] branch_imm;
    logic [25:0] jump_index;
`ifdef FETCH_INSTR_CNT_EN
    logic [31:0] instr_count;
`endif

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
`ifdef FETCH_INSTR_CNT_EN
        .instr_count (instr_count),
`endif
        .instr_ready (instr_ready),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .branch_imm  (branch_imm),
        .jump_index  (jump_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;   // fetch address this record expects
        logic [31:0] data;
        logic        br;
        logic        z;
        logic        j;
        logic [31:0] imm;
        logic [25:0] idx;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
    endtask

    task automatic ack_word(input logic [31:0] data, input logic [31:0] addr);
        @(negedge clk);
        check("addr_stable", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb.push_back('{data, addr});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic take(input logic br, input logic z, input logic j,
                        input logic [31:0] imm, input logic [25:0] idx, input int stall);
        exp_t e;
        int   n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", {31'd0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0 entries expected=1");
            e = '{32'd0, 32'd0};
        end else begin
            e = sb.pop_front();
        end
        check("instr", instr, e.instr);
        check("instr_pc", instr_pc, e.pc);
        for (int s = 0; s < stall; s++) begin
            // Stray ack and decoder controls while not accepting must be ignored.
            imem_ack   = (s == 1);
            imem_rdata = 32'hDEAD_BEEF;
            jump       = 1'b1;
            jump_index = 26'h3FF_FFFF;
            @(negedge clk);
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_instr", instr, e.instr);
            check("hold_pc", instr_pc, e.pc);
            check("hold_no_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        zero        = z;
        jump        = j;
        branch_imm  = imm;
        jump_index  = idx;
        @(negedge clk);
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        branch_imm  = 32'd0;
        jump_index  = 26'd0;
        hs_cnt++;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h2000_0000, 0, 0, 0, 32'h0,         26'h0,       0};
        vecs[1]  = '{32'h0000_0004, 32'h2000_0001, 0, 0, 0, 32'h0,         26'h0,       5};
        vecs[2]  = '{32'h0000_0008, 32'h0800_0010, 0, 0, 1, 32'h0,         26'h10,      0};
        vecs[3]  = '{32'h0000_0040, 32'h1000_FFFE, 1, 1, 0, 32'hFFFF_FFFE, 26'h0,       0};
        vecs[4]  = '{32'h0000_003C, 32'h0800_0010, 0, 0, 1, 32'h0,         26'h10,      0};
        vecs[5]  = '{32'h0000_0040, 32'h1000_FFFE, 1, 0, 0, 32'hFFFF_FFFE, 26'h0,       0};
        vecs[6]  = '{32'h0000_0044, 32'h2000_0006, 1, 1, 0, 32'h03FF_FFF2, 26'h0,       0};
        vecs[7]  = '{32'h1000_0010, 32'h0800_0100, 1, 1, 1, 32'h0000_0005, 26'h0000100, 0};
        vecs[8]  = '{32'h1000_0400, 32'h2000_0008, 1, 1, 0, 32'h3BFF_FEFE, 26'h0,       0};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h2000_0009, 0, 0, 0, 32'h0,         26'h0,       0};
        vecs[10] = '{32'h0000_0000, 32'h2000_000A, 0, 0, 0, 32'h0,         26'h0,       0};

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        branch_imm  = 32'd0;
        jump_index  = 26'd0;

        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_addr", imem_addr, DEFAULT_RESET_PC);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            wait_req(vecs[i].addr);
            ack_word(vecs[i].data, vecs[i].addr);
            take(vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].imm, vecs[i].idx, vecs[i].stall);
        end
        check("sb_drained", sb.size(), 32'd0);
`ifdef FETCH_INSTR_CNT_EN
        check("count", instr_count, 32'(hs_cnt));
`endif

        // Jump to 0x20, then reset while that request is outstanding.
        wait_req(32'h0000_0004);
        ack_word(32'h0800_0008, 32'h0000_0004);
        take(1'b0, 1'b0, 1'b1, 32'd0, 26'h8, 0);
        wait_req(32'h0000_0020);
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_addr", imem_addr, DEFAULT_RESET_PC);
        check("arst_instr", instr, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        imem_ack   = 1'b0;
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_instr", instr, 32'd0);
`ifdef FETCH_INSTR_CNT_EN
        check("count_rst", instr_count, 32'd0);
`endif
        wait_req(DEFAULT_RESET_PC);
        ack_word(32'h1234_5678, DEFAULT_RESET_PC);
        take(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0);
        wait_req(32'h0000_0004);
        check("sb_final", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
